bin2bcd_fsmd: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3 FSMD) placed directly downstream of the

---
 rtl/bin2bcd_fsmd_pkg.sv | 30 +++
 rtl/bin2bcd_fsmd_bcd_add3.sv | 14 +
 rtl/bin2bcd_fsmd.sv | 120 ++++++++++++
 tb/tb_bin2bcd_fsmd.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_fsmd_pkg.sv
// Shared definitions for the binary-to-BCD converter: state encoding, digit-count helper
// and, when BIN2BCD_SEG_EN is defined, the 7-segment patterns ({g,f,e,d,c,b,a}, active-high).
package bin2bcd_fsmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ceil(width * log10(2)) with log10(2) ~= 0.301 (gives 3 for width 8)
    function automatic int digits_for(input int width);
        return (width * 301 + 999) / 1000;
    endfunction

`ifdef BIN2BCD_SEG_EN
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
`endif

endpackage

// File: rtl/bin2bcd_fsmd_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the left shift.
module bcd_add3 (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    always_comb begin
        d_out = d_in;
        if (d_in >= 4'd5) begin
            d_out = d_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_fsmd.sv
// Sequential shift-and-add-3 binary-to-BCD converter (IDLE/SHIFT/DONE FSMD).
// Optional 7-segment decode of the registered result is enabled by defining BIN2BCD_SEG_EN.
module bin2bcd_fsmd
    import bin2bcd_fsmd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    localparam int DIGITS = digits_for(WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN2BCD_SEG_EN
    ,
    output logic [7*DIGITS-1:0]   seg_out
`endif
);

    localparam int BCD_W = 4 * DIGITS;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_sh_q, bin_sh_d;
    logic [BCD_W-1:0]   bcd_sh_q, bcd_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W+WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .d_in  (bcd_sh_q[4*gi +: 4]),
                .d_out (adj[4*gi +: 4])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        bin_sh_d  = bin_sh_q;
        bcd_sh_d  = bcd_sh_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        // The corrected digits never overflow for inputs below 2^WIDTH, so the dropped MSB is always 0.
        shifted   = {adj, bin_sh_q} << 1;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    bin_sh_d = bin_in;
                    bcd_sh_d = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = SHIFT;
                end else begin
                    state_d  = IDLE;
                end
            end
            SHIFT: begin
                bcd_sh_d = shifted[BCD_W+WIDTH-1:WIDTH];
                bin_sh_d = shifted[WIDTH-1:0];
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_out_d = shifted[BCD_W+WIDTH-1:WIDTH];
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bin_sh_q  <= '0;
            bcd_sh_q  <= '0;
            cnt_q     <= '0;
            bcd_out_q <= '0;
        end else begin
            state_q   <= state_d;
            bin_sh_q  <= bin_sh_d;
            bcd_sh_q  <= bcd_sh_d;
            cnt_q     <= cnt_d;
            bcd_out_q <= bcd_out_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_out_q;

`ifdef BIN2BCD_SEG_EN
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_seg
            assign seg_out[7*gi +: 7] = seg_decode(bcd_out_q[4*gi +: 4]);
        end
    endgenerate
`endif

endmodule

// File: tb/tb_bin2bcd_fsmd.sv
// Directed self-checking bench for bin2bcd_fsmd (seg_out checks only when BIN2BCD_SEG_EN is defined).
module tb_bin2bcd_fsmd;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
`ifdef BIN2BCD_SEG_EN
    logic [20:0] seg_out;
`endif

    int checks = 0;
    int errors = 0;

    bin2bcd_fsmd dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef BIN2BCD_SEG_EN
        ,
        .seg_out (seg_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] golden(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Called at a negedge; returns with the cycle after the done pulse sampled.
    task automatic run_conv(input logic [7:0] v, input logic [11:0] exp, input string tag);
        int n;
        int busy_n;
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 8'd0;
        n      = 1;
        busy_n = 0;
        while (!done && n < 20) begin
            if (busy) busy_n++;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 9);
        check({tag, "_busycycles"}, busy_n, 8);
        check({tag, "_done"}, {31'd0, done}, 1);
        check({tag, "_nobusy_at_done"}, {31'd0, busy}, 0);
        check({tag, "_bcd"}, {20'd0, bcd_out}, {20'd0, exp});
        @(negedge clk);
        check({tag, "_done_onecycle"}, {31'd0, done}, 0);
    endtask

    initial begin
        int done_cnt;
        int last_done;
        int gap_bad;
        logic [11:0] hand_exp [5];
        logic [7:0]  hand_in [5];

        hand_in  = '{8'd0, 8'd9, 8'd99, 8'd100, 8'd128};
        hand_exp = '{12'h000, 12'h009, 12'h099, 12'h100, 12'h128};

        // T1: reset
        reset  = 1'b0;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t1_busy", {31'd0, busy}, 0);
        check("t1_done", {31'd0, done}, 0);
        check("t1_bcd", {20'd0, bcd_out}, 32'h000);
`ifdef BIN2BCD_SEG_EN
        check("t1_seg", {11'd0, seg_out}, {11'd0, 7'b0111111, 7'b0111111, 7'b0111111});
`endif

        // T2: maximum value, bin_in cleared during SHIFT inside run_conv
        run_conv(8'd255, 12'h255, "t2_255");

        // T3: hand-computed vectors then full sweep
        for (int i = 0; i < 5; i++) begin
            run_conv(hand_in[i], hand_exp[i], $sformatf("t3_dir%0d", hand_in[i]));
        end
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), golden(v), $sformatf("t3_sweep%0d", v));
        end

        // T4: start held high, back-to-back conversions every 9 cycles
        start     = 1'b1;
        bin_in    = 8'd42;
        done_cnt  = 0;
        last_done = 0;
        gap_bad   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy && done) gap_bad++;
            if (done) begin
                if (done_cnt == 0) begin
                    if (i != 9) gap_bad++;
                end else if (i - last_done != 9) begin
                    gap_bad++;
                end
                check($sformatf("t4_bcd_at%0d", i), {20'd0, bcd_out}, 32'h042);
                done_cnt++;
                last_done = i;
            end
        end
        check("t4_done_count", done_cnt, 4);
        check("t4_gap_errors", gap_bad, 0);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_idle_busy", {31'd0, busy}, 0);

        // T5: reset mid-SHIFT discards the conversion
        start  = 1'b1;
        bin_in = 8'd200;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_before_reset", {31'd0, busy}, 1);
        reset = 1'b0;
        #1;
        check("t5_reset_bcd", {20'd0, bcd_out}, 32'h000);
        check("t5_reset_busy", {31'd0, busy}, 0);
        check("t5_reset_done", {31'd0, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("t5_no_activity", done_cnt, 0);
        check("t5_bcd_still0", {20'd0, bcd_out}, 32'h000);
        run_conv(8'd17, 12'h017, "t5_17");

`ifdef BIN2BCD_SEG_EN
        // T6: segment decode
        run_conv(8'd8, 12'h008, "t6_8");
        check("t6_seg", {11'd0, seg_out}, {11'd0, 7'b0111111, 7'b0111111, 7'b1111111});
        run_conv(8'd123, 12'h123, "t6_123");
        check("t6_seg123", {11'd0, seg_out}, {11'd0, 7'b0000110, 7'b1011011, 7'b1001111});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
